// File: rtl/dma_addr_gen_if.sv
// dma_addr_gen_if: instruction/data bus of the DMA address generator.
//   VALID    instruction strobe; I is sampled only while high
//   I        3-bit instruction code
//   CEN      count enable, qualifies the COUNT instruction
//   DATA_IN  load data (W bits)
//   DATA_OUT read data, zero while no read is in progress
//   OEDATA   high while DATA_OUT carries a read result
//   ADDR     current address counter
//   DONE     transfer-complete flag
// The master modport drives instructions; the slave modport is the generator.
interface dma_addr_gen_if #(
    parameter int unsigned W = 16
);
    logic         VALID;
    logic [2:0]   I;
    logic         CEN;
    logic [W-1:0] DATA_IN;
    logic [W-1:0] DATA_OUT;
    logic         OEDATA;
    logic [W-1:0] ADDR;
    logic         DONE;

    modport master (
        output VALID, I, CEN, DATA_IN,
        input  DATA_OUT, OEDATA, ADDR, DONE
    );

    modport slave (
        input  VALID, I, CEN, DATA_IN,
        output DATA_OUT, OEDATA, ADDR, DONE
    );
endinterface

// File: rtl/dma_addr_gen.sv
// dma_addr_gen: DMA address / word-count generator.
//   CLK  single clock, all state updates on the rising edge
//   RST  synchronous active-high reset, clears every register
//   bus  dma_addr_gen_if slave modport (instructions in, ADDR/DONE/read data out)
// State: AR (address reload), AC (address counter), WR (word-count reload),
// WC (word counter), CR (control: [1:0] mode, [2] decrement, [3] auto-reload).
module dma_addr_gen #(
    parameter int unsigned W = 16
) (
    input  logic          CLK,
    input  logic          RST,
    dma_addr_gen_if.slave bus
);
    localparam logic [2:0] OpWrcr   = 3'b000;
    localparam logic [2:0] OpRdcr   = 3'b001;
    localparam logic [2:0] OpRdwc   = 3'b010;
    localparam logic [2:0] OpRdac   = 3'b011;
    localparam logic [2:0] OpReinit = 3'b100;
    localparam logic [2:0] OpLdaddr = 3'b101;
    localparam logic [2:0] OpLdwc   = 3'b110;
    localparam logic [2:0] OpCount  = 3'b111;

    localparam logic [W-1:0] One = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] ar_q, ar_d;
    logic [W-1:0] ac_q, ac_d;
    logic [W-1:0] wr_q, wr_d;
    logic [W-1:0] wc_q, wc_d;
    logic [3:0]   cr_q, cr_d;

    logic [1:0]   mode;
    logic         done;
    logic [W-1:0] ac_step;
    logic [W-1:0] wc_step;
    logic [W-1:0] wc_reinit;

    assign mode = cr_q[1:0];

    // DONE uses only registered state, so a CR write affects it from the next cycle.
    always_comb begin
        done = 1'b0;
        unique case (mode)
            2'b00: done = (wc_q == One);
            2'b01: done = (wc_q == wr_q);
            2'b10: done = (ac_q == wr_q);
            2'b11: done = (wc_q == '0);
            default: done = 1'b0;
        endcase
    end

    always_comb begin
        ac_step   = cr_q[2] ? (ac_q - One) : (ac_q + One);
        wc_step   = wc_q;
        unique case (mode)
            2'b00:   wc_step = wc_q - One;
            2'b01:   wc_step = wc_q + One;
            2'b10:   wc_step = wc_q;
            2'b11:   wc_step = wc_q - One;
            default: wc_step = wc_q;
        endcase
        // Mode 01 counts up from zero towards WR.
        wc_reinit = (mode == 2'b01) ? '0 : wr_q;
    end

    always_comb begin
        ar_d = ar_q;
        ac_d = ac_q;
        wr_d = wr_q;
        wc_d = wc_q;
        cr_d = cr_q;
        if (bus.VALID) begin
            unique case (bus.I)
                OpWrcr: cr_d = bus.DATA_IN[3:0];
                OpRdcr, OpRdwc, OpRdac: ;
                OpReinit: begin
                    ac_d = ar_q;
                    wc_d = wc_reinit;
                end
                OpLdaddr: begin
                    ar_d = bus.DATA_IN;
                    ac_d = bus.DATA_IN;
                end
                OpLdwc: begin
                    wr_d = bus.DATA_IN;
                    wc_d = (mode == 2'b01) ? '0 : bus.DATA_IN;
                end
                OpCount: begin
                    if (bus.CEN) begin
                        if (!done || (!cr_q[3] && mode == 2'b11)) begin
                            // Mode 11 free-runs through DONE unless auto-reload is set.
                            ac_d = ac_step;
                            wc_d = wc_step;
                        end else if (cr_q[3]) begin
                            ac_d = ar_q;
                            wc_d = wc_reinit;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.DATA_OUT = '0;
        bus.OEDATA   = 1'b0;
        if (bus.VALID) begin
            unique case (bus.I)
                OpRdcr: begin
                    bus.DATA_OUT = {{(W-4){1'b0}}, cr_q};
                    bus.OEDATA   = 1'b1;
                end
                OpRdwc: begin
                    bus.DATA_OUT = wc_q;
                    bus.OEDATA   = 1'b1;
                end
                OpRdac: begin
                    bus.DATA_OUT = ac_q;
                    bus.OEDATA   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ADDR = ac_q;
    assign bus.DONE = done;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ar_q <= '0;
            ac_q <= '0;
            wr_q <= '0;
            wc_q <= '0;
            cr_q <= '0;
        end else begin
            ar_q <= ar_d;
            ac_q <= ac_d;
            wr_q <= wr_d;
            wc_q <= wc_d;
            cr_q <= cr_d;
        end
    end
endmodule
